// File: rtl/diff_decoder_pkg.sv
// Shared types and constants for the differential (XOR) serial decoder.
// The FSM state encoding, byte width and default sync word live here.
package diff_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] SYNC_WORD_DEFAULT = 8'hA5;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // MSB-first serial assembly: the newest bit lands in the LSB.
    function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] r,
                                                   input logic b);
        return {r[BYTE_W-2:0], b};
    endfunction

endpackage

// File: rtl/diff_decoder_if.sv
// Serial-in / byte-out bundle between the line sampler, the decoder and the consumer.
// The decoder attaches through the slave modport; the driving side uses master.
interface diff_decoder_if;
    import diff_pkg::*;

    logic              in_valid;
    logic              in;
    logic              bit_valid;
    logic              bit_out;
    logic              locked;
    logic              out_valid;
    logic [BYTE_W-1:0] out_data;
    logic              out_ready;
    logic              overflow;

    modport master (
        output in_valid,
        output in,
        output out_ready,
        input  bit_valid,
        input  bit_out,
        input  locked,
        input  out_valid,
        input  out_data,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  in,
        input  out_ready,
        output bit_valid,
        output bit_out,
        output locked,
        output out_valid,
        output out_data,
        output overflow
    );

endinterface

// File: rtl/diff_decoder_byte_fifo2.sv
// Two-entry byte FIFO with a sticky overflow flag. A push into a full FIFO is
// accepted only when the head is popped on the same edge; otherwise it is dropped.
module byte_fifo2
    import diff_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [BYTE_W-1:0] head,
    output logic              overflow
);

    logic [BYTE_W-1:0] mem_reg [2];
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [1:0]        count_reg;
    logic [1:0]        count_next;
    logic              overflow_reg;
    logic              pop_ok;
    logic              push_ok;

    assign full     = (count_reg == 2'd2);
    assign empty    = (count_reg == 2'd0);
    assign head     = mem_reg[rd_ptr_reg];
    assign overflow = overflow_reg;

    assign pop_ok  = pop & ~empty;
    // When full, wr_ptr equals rd_ptr, so the incoming byte reuses the slot being popped.
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (pop_ok) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_next;
            if (push && !push_ok) begin
                overflow_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/diff_decoder.sv
// Differential decoder: x[n] = y[n] ^ y[n-1], sync-word hunt, fixed-length
// MSB-first frame assembly, and a 2-entry valid/ready output buffer.
module diff_decoder
    import diff_pkg::*;
#(
    parameter logic [BYTE_W-1:0] SYNC_WORD   = SYNC_WORD_DEFAULT,
    parameter int                FRAME_BYTES = 4
) (
    input  logic           clk,
    input  logic           reset,
    diff_decoder_if.slave  bus
);

    localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

    state_t            state_reg,    state_next;
    logic [BYTE_W-1:0] shreg_reg,    shreg_next;
    logic [BYTE_W-1:0] asm_reg,      asm_next;
    logic [2:0]        bit_cnt_reg,  bit_cnt_next;
    logic [7:0]        byte_cnt_reg, byte_cnt_next;
    logic              prev_reg;
    logic              bit_valid_reg;
    logic              bit_out_reg;

    logic              dec;
    logic [BYTE_W-1:0] hunt_window;
    logic              push;
    logic [BYTE_W-1:0] push_data;
    logic              fifo_full;
    logic              fifo_empty;

    assign dec         = bus.in ^ prev_reg;
    assign hunt_window = shift_in(shreg_reg, dec);
    assign push_data   = shift_in(asm_reg, dec);

    always_comb begin
        state_next    = state_reg;
        shreg_next    = shreg_reg;
        asm_next      = asm_reg;
        bit_cnt_next  = bit_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        push          = 1'b0;

        if (bus.in_valid) begin
            case (state_reg)
                HUNT: begin
                    if (hunt_window == SYNC_WORD) begin
                        state_next    = LOCKED;
                        shreg_next    = '0;
                        bit_cnt_next  = 3'd0;
                        byte_cnt_next = 8'd0;
                    end else begin
                        shreg_next = hunt_window;
                    end
                end
                LOCKED: begin
                    asm_next = push_data;
                    if (bit_cnt_reg == 3'd7) begin
                        push         = 1'b1;
                        bit_cnt_next = 3'd0;
                        if (byte_cnt_reg == LAST_BYTE) begin
                            // Frame done: the next sync must be built from 8 fresh bits.
                            state_next    = HUNT;
                            byte_cnt_next = 8'd0;
                            shreg_next    = '0;
                        end else begin
                            byte_cnt_next = byte_cnt_reg + 8'd1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= HUNT;
            shreg_reg     <= '0;
            asm_reg       <= '0;
            bit_cnt_reg   <= 3'd0;
            byte_cnt_reg  <= 8'd0;
            prev_reg      <= 1'b0;
            bit_valid_reg <= 1'b0;
            bit_out_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shreg_reg     <= shreg_next;
            asm_reg       <= asm_next;
            bit_cnt_reg   <= bit_cnt_next;
            byte_cnt_reg  <= byte_cnt_next;
            bit_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                prev_reg    <= bus.in;
                bit_out_reg <= dec;
            end
        end
    end

    byte_fifo2 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (bus.out_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (bus.out_data),
        .overflow  (bus.overflow)
    );

    assign bus.bit_valid = bit_valid_reg;
    assign bus.bit_out   = bit_out_reg;
    assign bus.locked    = (state_reg == LOCKED);
    assign bus.out_valid = ~fifo_empty;

endmodule

// File: tb/tb_diff_decoder.sv
// Directed, table-driven bench for diff_decoder: a local XOR encoder produces
// the line stream and a negedge monitor collects every byte the consumer takes.
module tb_diff_decoder;

    logic clk;
    logic reset;
    logic enc;
    logic [7:0] rx_q[$];
    int checks;
    int errors;

    diff_decoder_if bus ();

    diff_decoder u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            rx_q.push_back(bus.out_data);
        end
    end

    typedef struct packed {
        logic in_bit;
        logic exp_bit;
    } dec_vec_t;

    typedef struct packed {
        logic [7:0]       sync;
        logic [2:0]       n_data;
        logic [3:0][7:0]  d;
        logic [1:0]       gap;
        logic             ready;
        logic             exp_lock;
        logic [2:0]       n_exp;
        logic [3:0][7:0]  exp;
    } frame_vec_t;

    dec_vec_t   dv [5];
    frame_vec_t fv [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in        = 1'b0;
        reset         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        enc   = 1'b0;
        rx_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic x, input int gap);
        enc          = x ^ enc;
        bus.in       = enc;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        idle(gap);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], gap);
        end
    endtask

    task automatic check_queue(input string name, input logic [7:0] exp_b [4], input int n);
        check({name, "_count"}, rx_q.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < rx_q.size()) check({name, "_byte"}, rx_q[k], exp_b[k]);
        end
    endtask

    initial begin
        logic [7:0] exp_b [4];
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        enc          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in       = 1'b0;
        bus.out_ready = 1'b0;

        // in = 1,1,0,0,1 decodes to 1,0,1,0,1
        dv[0] = '{in_bit: 1'b1, exp_bit: 1'b1};
        dv[1] = '{in_bit: 1'b1, exp_bit: 1'b0};
        dv[2] = '{in_bit: 1'b0, exp_bit: 1'b1};
        dv[3] = '{in_bit: 1'b0, exp_bit: 1'b0};
        dv[4] = '{in_bit: 1'b1, exp_bit: 1'b1};

        fv[0] = '{sync: 8'hA5, n_data: 3'd4, d: 32'h78563412, gap: 2'd0, ready: 1'b1,
                  exp_lock: 1'b1, n_exp: 3'd4, exp: 32'h78563412};
        fv[1] = '{sync: 8'hA5, n_data: 3'd4, d: 32'h78563412, gap: 2'd3, ready: 1'b1,
                  exp_lock: 1'b1, n_exp: 3'd4, exp: 32'h78563412};
        fv[2] = '{sync: 8'hA4, n_data: 3'd1, d: 32'h00000012, gap: 2'd0, ready: 1'b1,
                  exp_lock: 1'b0, n_exp: 3'd0, exp: 32'h00000000};

        // Reset state
        do_reset();
        check("rst_bit_valid", bus.bit_valid, 1'b0);
        check("rst_bit_out",   bus.bit_out,   1'b0);
        check("rst_locked",    bus.locked,    1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data",  bus.out_data,  8'h00);
        check("rst_overflow",  bus.overflow,  1'b0);

        // Pure decode
        for (int i = 0; i < 5; i++) begin
            bus.in       = dv[i].in_bit;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("dec_bit_out",   bus.bit_out,   dv[i].exp_bit);
            check("dec_bit_valid", bus.bit_valid, 1'b1);
            check("dec_locked",    bus.locked,    1'b0);
            $display("decode step %0d: in=%0b bit_out=%0b", i, dv[i].in_bit, bus.bit_out);
        end
        bus.in_valid = 1'b0;
        idle(1);
        check("dec_bit_valid_idle", bus.bit_valid, 1'b0);

        // Frame vectors: normal, gapped, near-miss sync
        for (int v = 0; v < 3; v++) begin
            do_reset();
            bus.out_ready = fv[v].ready;
            send_byte(fv[v].sync, int'(fv[v].gap));
            check("lock_after_sync", bus.locked, fv[v].exp_lock);
            for (int k = 0; k < int'(fv[v].n_data); k++) begin
                send_byte(fv[v].d[k], int'(fv[v].gap));
            end
            check("lock_after_frame", bus.locked, 1'b0);
            idle(6);
            for (int k = 0; k < 4; k++) exp_b[k] = fv[v].exp[k];
            check_queue("frame_rx", exp_b, int'(fv[v].n_exp));
            check("frame_overflow", bus.overflow, 1'b0);
            check("frame_drained", bus.out_valid, 1'b0);
            $display("frame vector %0d: received %0d bytes", v, rx_q.size());
        end

        // Backpressure: two bytes fit, the last two are dropped
        do_reset();
        bus.out_ready = 1'b0;
        send_byte(8'hA5, 0);
        send_byte(8'h12, 0);
        check("bp_valid_b1", bus.out_valid, 1'b1);
        check("bp_data_b1",  bus.out_data,  8'h12);
        send_byte(8'h34, 0);
        check("bp_ovf_b2",   bus.overflow,  1'b0);
        send_byte(8'h56, 0);
        check("bp_ovf_b3",   bus.overflow,  1'b1);
        send_byte(8'h78, 0);
        idle(3);
        check("bp_valid_hold", bus.out_valid, 1'b1);
        check("bp_data_hold",  bus.out_data,  8'h12);
        check("bp_locked",     bus.locked,    1'b0);
        bus.out_ready = 1'b1;
        idle(5);
        exp_b = '{8'h12, 8'h34, 8'h00, 8'h00};
        check_queue("bp_rx", exp_b, 2);
        check("bp_overflow_sticky", bus.overflow, 1'b1);
        check("bp_drained", bus.out_valid, 1'b0);
        $display("backpressure: received %0d bytes, overflow=%0b", rx_q.size(), bus.overflow);

        // Reset mid-frame, then a fresh frame
        do_reset();
        bus.out_ready = 1'b1;
        send_byte(8'hA5, 0);
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        check("mid_locked", bus.locked, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_bit_valid", bus.bit_valid, 1'b0);
        check("mid_rst_bit_out",   bus.bit_out,   1'b0);
        check("mid_rst_locked",    bus.locked,    1'b0);
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_out_data",  bus.out_data,  8'h00);
        check("mid_rst_overflow",  bus.overflow,  1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        enc   = 1'b0;
        rx_q.delete();
        send_byte(8'hA5, 0);
        check("mid_relock", bus.locked, 1'b1);
        send_byte(8'h9A, 0);
        send_byte(8'hBC, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hF0, 0);
        idle(6);
        exp_b = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
        check_queue("mid_rx", exp_b, 4);
        check("mid_overflow", bus.overflow, 1'b0);
        $display("reset mid-frame: received %0d bytes", rx_q.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
